axi_cmd_arbiter: RTL
====================

// Module: axi_cmd_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single APB command FIFO between the AXI write-address (AW)
//  and read-address (AR) channels of the bridge. Accepts one address per handshake, tags it
//  with direction, registers it and presents it on a valid/ready port to the FIFO input.
//  Throttles acceptance against an outstanding-transaction credit returned by the APB side.
// PARAMETERS
//  ADDR_WIDTH  32                      address width of AW/AR and of the command payload
//  MAX_OUT     4                       max commands pushed but not yet completed (>=1)
//  CNT_WIDTH   $clog2(MAX_OUT+1)       width of outstanding counter
// PORTS
//  clk          in   1             clock, all logic on rising edge
//  rst          in   1             asynchronous reset, active-high
//  aw_vld       in   1             write address valid
//  aw_rdy       out  1             write address ready (combinational)
//  aw_addr      in   ADDR_WIDTH    write address
//  ar_vld       in   1             read address valid
//  ar_rdy       out  1             read address ready (combinational)
//  ar_addr      in   ADDR_WIDTH    read address
//  cmd_vld      out  1             command valid to FIFO src side (registered)
//  cmd_rdy      in   1             FIFO src ready
//  cmd_data     out  ADDR_WIDTH+1  {is_write, addr} (registered)
//  cmd_done     in   1             one-cycle pulse: APB side finished one command
//  outstanding  out  CNT_WIDTH     commands accepted and not yet done (registered)
//  last_grant   out  1             1 = last grant was AR, 0 = AW (registered)
//  err_underflow out 1             sticky: cmd_done seen with outstanding==0
// BEHAVIOUR
//  Reset (async, rst=1): cmd_vld=0, cmd_data=0, outstanding=0, last_grant=1 (AW wins first),
//   err_underflow=0, state EMPTY. Any held command is discarded; aw_rdy/ar_rdy=0 while rst=1.
//  State: EMPTY (cmd_vld=0) / FULL (cmd_vld=1). Output register is one entry deep.
//  slot_free = (state==EMPTY) | cmd_rdy ; credit_ok = (outstanding != MAX_OUT) (registered
//   value only; no same-cycle bypass of cmd_done).
//  Grant (combinational, when slot_free & credit_ok & !rst):
//   only aw_vld -> AW; only ar_vld -> AR; both -> the one NOT equal to last_grant.
//   aw_rdy = grant_aw ; ar_rdy = grant_ar ; at most one of them high in any cycle.
//   Ready does not depend on the requester's own valid beyond selection (no other loops).
//  Accept = granted vld & rdy. Next edge: cmd_data <= {is_write, addr}, cmd_vld <= 1,
//   state FULL, last_grant <= (granted==AR), outstanding +1.
//  FULL: cmd_data/cmd_vld held stable until cmd_rdy. On cmd_rdy without new accept ->
//   cmd_vld <= 0, EMPTY. On cmd_rdy with accept same cycle -> stays FULL with new data
//   (back-to-back, one command per cycle sustained).
//  Latency: upstream handshake at edge N -> cmd_vld high after edge N (visible cycle N+1).
//  outstanding: +1 on accept, -1 on cmd_done, unchanged if both or neither. Never exceeds
//   MAX_OUT. cmd_done at 0 -> counter stays 0, err_underflow <= 1 (cleared only by reset).
//  At outstanding==MAX_OUT: aw_rdy=ar_rdy=0 even if slot free; resumes cycle after cmd_done.
//  cmd_vld not gated by credit: a held command is still offered when credit is exhausted.
//  Fairness: with both requesters continuously valid, grants strictly alternate AW,AR,AW...
// TESTING
//  1 Reset, aw_vld=1 addr=0x100 only, cmd_rdy=1 -> aw_rdy=1 cycle 0; cmd_vld=1 data={1,0x100}
//    next cycle; outstanding=1.
//  2 aw_vld & ar_vld held 4 cycles, cmd_rdy=1, cmd_done each cycle from cycle 1 -> grant order
//    AW,AR,AW,AR; cmd_data is_write 1,0,1,0; outstanding stays 1.
//  3 cmd_rdy=0 for 5 cycles with command held -> cmd_data stable, aw_rdy=ar_rdy=0; on
//    cmd_rdy=1 next request accepted same cycle, cmd_vld stays 1 with new data.
//  4 MAX_OUT=4, 4 accepts, no cmd_done -> outstanding=4, rdys low; one cmd_done pulse ->
//    outstanding=3, rdy high the following cycle.
//  5 cmd_done with outstanding=0 -> outstanding=0, err_underflow=1 and stays 1 until reset.
//  6 rst pulsed while FULL and outstanding=2 -> cmd_vld=0, outstanding=0, last_grant=1
//    immediately (async); first post-reset contention grants AW.

Source files
------------

// File: rtl/axi_cmd_arbiter_if.sv
// AW/AR address channels and the command output port of the command arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding bridge's view.
interface axi_cmd_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  aw_vld;
   logic                  aw_rdy;
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic                  ar_vld;
   logic                  ar_rdy;
   logic [ADDR_WIDTH-1:0] ar_addr;
   logic                  cmd_vld;
   logic                  cmd_rdy;
   logic [ADDR_WIDTH:0]   cmd_data;

   modport slave (
      input  aw_vld, aw_addr, ar_vld, ar_addr, cmd_rdy,
      output aw_rdy, ar_rdy, cmd_vld, cmd_data
   );

   modport master (
      output aw_vld, aw_addr, ar_vld, ar_addr, cmd_rdy,
      input  aw_rdy, ar_rdy, cmd_vld, cmd_data
   );
endinterface

// File: rtl/axi_cmd_arbiter.sv
// Round-robin AW/AR arbiter into a one-entry registered command slot, throttled by an
// outstanding-command credit counter that the APB side decrements with cmd_done.
module axi_cmd_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MAX_OUT    = 4,
   parameter int unsigned CNT_WIDTH  = $clog2(MAX_OUT + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   axi_cmd_arbiter_if.slave     bus,
   input  logic                 i_cmd_done,
   output logic [CNT_WIDTH-1:0] o_outstanding,
   output logic                 o_last_grant,
   output logic                 o_err_underflow
);

   typedef enum logic {StEmpty, StFull} state_e;

   localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_WIDTH'(MAX_OUT);

   state_e                r_state;
   logic                  r_cmd_vld;
   logic [ADDR_WIDTH:0]   r_cmd_data;
   logic [CNT_WIDTH-1:0]  r_outstanding;
   logic                  r_last_grant;
   logic                  r_err_underflow;

   logic                  w_slot_free;
   logic                  w_credit_ok;
   logic                  w_can_grant;
   logic                  w_grant_aw;
   logic                  w_grant_ar;
   logic                  w_accept;
   logic [ADDR_WIDTH:0]   w_cmd_next;

   // Credit uses the registered count only; a same-cycle cmd_done frees a slot next cycle.
   assign w_slot_free = (r_state == StEmpty) | bus.cmd_rdy;
   assign w_credit_ok = (r_outstanding != LP_MAX);
   assign w_can_grant = w_slot_free & w_credit_ok & ~i_rst;

   // On contention, the requester that did not win last time gets the slot.
   assign w_grant_aw = w_can_grant & bus.aw_vld & (~bus.ar_vld | r_last_grant);
   assign w_grant_ar = w_can_grant & bus.ar_vld & (~bus.aw_vld | ~r_last_grant);
   assign w_accept   = w_grant_aw | w_grant_ar;
   assign w_cmd_next = w_grant_aw ? {1'b1, bus.aw_addr} : {1'b0, bus.ar_addr};

   assign bus.aw_rdy      = w_grant_aw;
   assign bus.ar_rdy      = w_grant_ar;
   assign bus.cmd_vld     = r_cmd_vld;
   assign bus.cmd_data    = r_cmd_data;
   assign o_outstanding   = r_outstanding;
   assign o_last_grant    = r_last_grant;
   assign o_err_underflow = r_err_underflow;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state         <= StEmpty;
         r_cmd_vld       <= 1'b0;
         r_cmd_data      <= '0;
         r_outstanding   <= '0;
         r_last_grant    <= 1'b1;
         r_err_underflow <= 1'b0;
      end else begin
         unique case (r_state)
            StEmpty: begin
               if (w_accept) begin
                  r_state    <= StFull;
                  r_cmd_vld  <= 1'b1;
                  r_cmd_data <= w_cmd_next;
               end
            end
            StFull: begin
               if (w_accept) begin
                  r_cmd_data <= w_cmd_next;
               end else if (bus.cmd_rdy) begin
                  r_state   <= StEmpty;
                  r_cmd_vld <= 1'b0;
               end
            end
            default: begin
               r_state   <= StEmpty;
               r_cmd_vld <= 1'b0;
            end
         endcase

         if (w_accept) begin
            r_last_grant <= w_grant_ar;
         end

         // A cmd_done with nothing outstanding is flagged and never wraps the counter.
         if (i_cmd_done && (r_outstanding == '0)) begin
            r_err_underflow <= 1'b1;
         end
         if (w_accept && !i_cmd_done) begin
            r_outstanding <= r_outstanding + CNT_WIDTH'(1);
         end else if (!w_accept && i_cmd_done && (r_outstanding != '0)) begin
            r_outstanding <= r_outstanding - CNT_WIDTH'(1);
         end
      end
   end

endmodule
